// File: rtl/ram_rom_arbiter.sv
// rtl/ram_rom_arbiter.sv - ROM-initialised RAM shared by two requesters (optional ARB_FIXED_PRIORITY_EN)
module ram_rom_arbiter #(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    output logic                  busy,
    input  logic                  req_a,
    input  logic                  we_a,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [DATA_WIDTH-1:0] wdata_a,
    output logic                  ack_a,
    output logic [DATA_WIDTH-1:0] rdata_a,
    input  logic                  req_b,
    input  logic                  we_b,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] wdata_b,
    output logic                  ack_b,
    output logic [DATA_WIDTH-1:0] rdata_b
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] INIT_LAST = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_IDLE  = 2'd1,
        S_SERVE = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] init_cnt;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // access captured at grant time, consumed in SERVE
    logic                  sel_b;
    logic                  lat_we;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic [DATA_WIDTH-1:0] serve_data;

    logic                  grant;
    logic                  grant_b;

`ifndef ARB_FIXED_PRIORITY_EN
    // 1 when B held the most recent grant; reset value lets A win the first tie
    logic                  last_b;
`endif

    function automatic logic [DATA_WIDTH-1:0] rom_word(input logic [ADDR_WIDTH-1:0] a);
        logic [3:0] w;
        w = 4'b0000;
        case (int'(a))
            0:       w = 4'b0100;
            1:       w = 4'b1100;
            2:       w = 4'b0110;
            3:       w = 4'b0111;
            default: w = 4'b0000;
        endcase
        return DATA_WIDTH'(w);
    endfunction

    assign busy = (state == S_INIT);

    // a write echoes its own data; a read returns the stored word
    assign serve_data = lat_we ? lat_wdata : mem[lat_addr];

    // FSM state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_INIT;
        end else begin
            state <= state_next;
        end
    end

    // next-state and arbitration decision
    always_comb begin
        state_next = state;
        grant      = 1'b0;
        grant_b    = 1'b0;
        case (state)
            S_INIT: begin
                if (init_cnt == INIT_LAST) begin
                    state_next = S_IDLE;
                end
            end
            S_IDLE: begin
                if (req_a || req_b) begin
                    grant      = 1'b1;
                    state_next = S_SERVE;
`ifdef ARB_FIXED_PRIORITY_EN
                    grant_b    = !req_a;
`else
                    grant_b    = req_b && (!req_a || !last_b);
`endif
                end
            end
            S_SERVE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_INIT;
            end
        endcase
    end

    // init counter, request capture, acknowledge and read-data registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            init_cnt  <= '0;
            sel_b     <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            ack_a     <= 1'b0;
            ack_b     <= 1'b0;
            rdata_a   <= '0;
            rdata_b   <= '0;
`ifndef ARB_FIXED_PRIORITY_EN
            last_b    <= 1'b1;
`endif
        end else begin
            ack_a <= 1'b0;
            ack_b <= 1'b0;
            if (state == S_INIT) begin
                init_cnt <= init_cnt + ADDR_WIDTH'(1);
            end
            if (grant) begin
                sel_b     <= grant_b;
                lat_we    <= grant_b ? we_b    : we_a;
                lat_addr  <= grant_b ? addr_b  : addr_a;
                lat_wdata <= grant_b ? wdata_b : wdata_a;
            end
            if (state == S_SERVE) begin
                if (sel_b) begin
                    ack_b   <= 1'b1;
                    rdata_b <= serve_data;
                end else begin
                    ack_a   <= 1'b1;
                    rdata_a <= serve_data;
                end
`ifndef ARB_FIXED_PRIORITY_EN
                last_b <= sel_b;
`endif
            end
        end
    end

    // RAM write port: ROM copy during INIT, granted write during SERVE
    always_ff @(posedge clock) begin
        if (state == S_INIT) begin
            mem[init_cnt] <= rom_word(init_cnt);
        end else if (state == S_SERVE && lat_we) begin
            mem[lat_addr] <= lat_wdata;
        end
    end

endmodule
